// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: data width, canonical NOP
// and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_START = 2'd0,
        FS_FETCH = 2'd1,
        FS_FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// hands each fetched word to decode over a valid/ready handshake.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_kill;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_addrPlus4;
    logic [1:0]      w_unusedPcBits;

    assign w_target       = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unusedPcBits = redirect_pc[1:0];
    assign w_addrPlus4    = imem_addr + 32'd4;

    // r_kill marks an outstanding request whose response must be dropped because
    // a redirect arrived while the address was still locked on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FS_START;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= '0;
            if_pcplus4 <= '0;
        end else begin
            case (r_state)
                FS_START: begin
                    r_state   <= FS_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= r_pc;
                end
                FS_FETCH: begin
                    if (redirect) begin
                        r_pc     <= w_target;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        if (imem_req && !imem_rvalid) begin
                            r_kill <= 1'b1;
                        end else begin
                            r_kill   <= 1'b0;
                            imem_req <= 1'b0;
                        end
                    end else if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= r_pc;
                    end else if (imem_rvalid) begin
                        imem_req <= 1'b0;
                        if (r_kill) begin
                            r_kill <= 1'b0;
                        end else begin
                            if_instr   <= imem_rdata;
                            if_pc      <= imem_addr;
                            if_pcplus4 <= w_addrPlus4;
                            if_valid   <= 1'b1;
                            r_pc       <= w_addrPlus4;
                            r_state    <= FS_FULL;
                        end
                    end
                end
                FS_FULL: begin
                    if (redirect) begin
                        r_pc     <= w_target;
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        r_state  <= FS_FETCH;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        r_state  <= FS_FETCH;
                    end
                end
                default: begin
                    r_state <= FS_START;
                end
            endcase
        end
    end

endmodule
